// File: rtl/aes128_key_sched_ctrl.sv
// rtl/aes128_key_sched_ctrl.sv - sequential AES-128 key expansion sharing one external sbox
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     single-cycle request, accepted only when idle
//   key_in    128-bit cipher key (w0 = key_in[127:96], w3 = key_in[31:0])
//   sbox_out  result from the external combinational sbox
//   sbox_in   byte presented to the external sbox (0 when idle)
//   busy      high while the block owns the sbox
//   rk_valid  one-cycle strobe qualifying rk_out/rk_round
//   rk_round  round index of rk_out, 0..10
//   rk_out    current round key, held between strobes
//   done      one-cycle strobe together with the round-10 key

module aes128_key_sched_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [7:0]   sbox_out,
  output logic [7:0]   sbox_in,
  output logic         busy,
  output logic         rk_valid,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_out,
  output logic         done
);

  typedef enum logic {
    IDLE = 1'b0,
    SUB  = 1'b1
  } state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [7:0]  rcon;
  logic [31:0] temp;

  logic [31:0] tw;
  logic [31:0] w0n;
  logic [31:0] w1n;
  logic [31:0] w2n;
  logic [31:0] w3n;
  logic [7:0]  rcon_nx;

  // RotWord is folded into the byte selection: a1, a2, a3, a0 of w3.
  always_comb begin
    sbox_in = 8'h00;
    if (state == SUB) begin
      case (cnt)
        2'd0: sbox_in = rk_out[23:16];
        2'd1: sbox_in = rk_out[15:8];
        2'd2: sbox_in = rk_out[7:0];
        default: sbox_in = rk_out[31:24];
      endcase
    end
  end

  // The last substituted byte is taken live from sbox_out so the new key
  // lands on the same edge as the fourth lookup.
  always_comb begin
    tw      = {temp[31:24] ^ rcon, temp[23:16], temp[15:8], sbox_out};
    w0n     = rk_out[127:96] ^ tw;
    w1n     = rk_out[95:64] ^ w0n;
    w2n     = rk_out[63:32] ^ w1n;
    w3n     = rk_out[31:0] ^ w2n;
    rcon_nx = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
      rk_round <= 4'd0;
      rk_out   <= 128'd0;
      cnt      <= 2'd0;
      rcon     <= 8'h01;
      temp     <= 32'd0;
    end else begin
      rk_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          // busy stays up through the cycle the round-10 key is shown, so a
          // start in that cycle is still ignored.
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            rk_out   <= key_in;
            rk_round <= 4'd0;
            rk_valid <= 1'b1;
            rcon     <= 8'h01;
            cnt      <= 2'd0;
            busy     <= 1'b1;
            state    <= SUB;
          end
        end
        SUB: begin
          cnt <= cnt + 2'd1;
          case (cnt)
            2'd0: temp[31:24] <= sbox_out;
            2'd1: temp[23:16] <= sbox_out;
            2'd2: temp[15:8]  <= sbox_out;
            default: begin
              temp[7:0] <= sbox_out;
              rk_out    <= {w0n, w1n, w2n, w3n};
              rk_round  <= rk_round + 4'd1;
              rk_valid  <= 1'b1;
              if (rk_round == 4'd9) begin
                // Final round: leave rcon at 36, it is never advanced past it.
                done  <= 1'b1;
                state <= IDLE;
              end else begin
                rcon <= rcon_nx;
              end
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes128_key_sched_ctrl.md
Name: aes128_key_sched_ctrl

Overview:
Sequential AES-128 key-expansion controller that time-multiplexes one external combinational sbox instance. The sbox is shared with the datapath at the top level; the external mux is controlled by busy. On start, the block emits round keys 0..10 one at a time with a valid strobe. It sits between the key register and the round datapath of the AES_128 core.

Parameters:
None. The block is AES-128 only, with the round count fixed at 10.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  single-cycle request; sampled only in IDLE
key_in  input  128  cipher key; word w0 = key_in[127:96], w3 = key_in[31:0]
sbox_out  input  8  result from external sbox (combinational, same cycle)
sbox_in  output  8  byte driven to external sbox
busy  output  1  high whenever state != IDLE; top level grants the sbox to this block while busy
rk_valid  output  1  one-cycle strobe: rk_out/rk_round valid
rk_round  output  4  round index of rk_out, 0..10
rk_out  output  128  current round key; held between strobes
done  output  1  one-cycle strobe coincident with round-10 rk_valid

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values: state=IDLE, busy=0, rk_valid=0, done=0, rk_round=0, rk_out=0, sbox_in=0, byte counter=0, rcon=8'h01, temp=0.
- A reset asserted mid-operation aborts within one cycle, with all of the above values. No partial keys are emitted afterwards.
- States:
  - IDLE: on start=1, latch key_in into rk_out, set rk_round=0, pulse rk_valid, rcon=01, cnt=0, and go to SUB.
  - SUB: four cycles, cnt=0..3. Let w3=rk_out[31:0] with bytes a0..a3 MSB-first (RotWord order).
    - sbox_in is combinational from state/cnt: cnt0 = a1, cnt1 = a2, cnt2 = a3, cnt3 = a0.
    - sbox_out is captured into temp bytes t0..t3 on the same edge.
    - At cnt=3, the new key is computed using the live sbox_out for t3: tw = {t0^rcon, t1, t2, t3}, w0' = w0^tw, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
    - Also at cnt=3: register rk_out, increment rk_round, pulse rk_valid, rcon = xtime(rcon) (01,02,04,08,10,20,40,80,1b,36), cnt=0.
    - If the new rk_round=10, also pulse done and go to IDLE; otherwise stay in SUB.
- sbox_in = 0 in IDLE.
- Timing, with the start-sampling edge at cycle 0:
  - Round r key is visible with rk_valid=1 in cycle 1+4r, so round 0 is in cycle 1 and round 10 in cycle 41.
  - busy is high in cycles 1..41 and low in cycle 42.
  - The earliest accepted restart is a start sampled in cycle 42.
- start while busy is ignored, with no queuing. key_in is sampled only on the accepting edge; later changes have no effect.
- rk_valid is never high for two consecutive rounds closer than 4 cycles. rk_out is stable between strobes and retains the round-10 key after done.
- rcon update: xtime(80)=1b, and no rcon value beyond 36 is ever used.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse -> cycle 1: rk_round=0, rk_out=key; cycle 1 sbox_in=cf; cycle 5: rk_round=1, rk_out=a0fafe1788542cb123a339392a6c7605; cycle 41: rk_round=10, rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6, done=1.
- All-zero key -> round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e; exactly 11 rk_valid pulses and 1 done.
- start re-pulsed at cycles 10 and 41 with a different key_in -> ignored; round keys unchanged; busy low in cycle 42; a start at cycle 42 restarts, with round 0 at cycle 43.
- rst asserted at cycle 20 -> from cycle 21: busy=0, rk_valid=0, rk_out=0, sbox_in=0; no further strobes. A following start produces the correct FIPS sequence.
- Idle check: no start for 100 cycles after reset -> busy=0, rk_valid=0, done=0, sbox_in=0 throughout. A start coincident with rst=1 -> ignored.
- Cross-check all 44 words of a random key against a software model, including the rcon wrap (round 9 uses 1b, round 10 uses 36).
